// File: rtl/sram_word_controller.sv
// 32-bit word access over a 16-bit external SRAM.
// Two half-word phases (low then high); ready low freezes the pipeline.
module sram_word_controller #(
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] MEM_BASE    = 32'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  inout  wire  [15:0] SRAM_DQ,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N,
  output logic        SRAM_WE_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N
);

  typedef enum logic [1:0] {
    IDLE,
    LO,
    HI,
    DONE
  } state_t;

  localparam logic [2:0] LAST = 3'(WAIT_CYCLES);

  state_t      state_q;
  state_t      state_d;
  logic [2:0]  cnt_q;
  logic [2:0]  cnt_d;
  logic        op_wr_q;
  logic [16:0] word_q;
  logic [31:0] wdata_q;

  logic        req;
  logic        last;
  logic        drive;
  logic [31:0] offset;
  logic [16:0] word_in;
  logic        unused_offset;

  assign req     = wr_en | rd_en;
  assign last    = (cnt_q == LAST);
  assign offset  = address - MEM_BASE;
  assign word_in = offset[18:2];

  // Upper address bits are dropped: accesses wrap silently.
  assign unused_offset = ^{offset[31:19], offset[1:0]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready   = 1'b0;
    unique case (state_q)
      IDLE: begin
        ready = ~req;
        if (req) begin
          state_d = LO;
          cnt_d   = 3'd0;
        end
      end
      LO: begin
        if (last) begin
          state_d = HI;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      HI: begin
        if (last) begin
          state_d = DONE;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      DONE: begin
        ready   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 3'd0;
      op_wr_q   <= 1'b0;
      word_q    <= 17'd0;
      wdata_q   <= 32'd0;
      read_data <= 32'd0;
      SRAM_ADDR <= 18'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == IDLE && req) begin
        op_wr_q   <= wr_en;
        word_q    <= word_in;
        wdata_q   <= write_data;
        SRAM_ADDR <= {word_in, 1'b0};
      end
      if (state_q == LO && last) begin
        SRAM_ADDR <= {word_q, 1'b1};
        if (!op_wr_q) read_data[15:0] <= SRAM_DQ;
      end
      if (state_q == HI && last && !op_wr_q) begin
        read_data[31:16] <= SRAM_DQ;
      end
    end
  end

  // Strobe released on the last phase cycle so addr/data are stable at its rise.
  assign drive     = op_wr_q & ((state_q == LO) | (state_q == HI));
  assign SRAM_WE_N = ~(drive & ~last);
  assign SRAM_DQ   = drive ? ((state_q == HI) ? wdata_q[31:16]
                                              : wdata_q[15:0])
                           : 16'hzzzz;

  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_OE_N = 1'b0;

endmodule

// File: tb/tb_sram_word_controller.sv
// Randomized scoreboard bench for sram_word_controller.
// Word-level reference memory plus a half-word SRAM model.
module tb_sram_word_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en, rd_en;
  logic [31:0] address, write_data;
  wire  [31:0] read_data;
  wire         ready;
  wire  [15:0] sram_dq;
  wire  [17:0] sram_addr;
  wire         ub_n, lb_n, we_n, ce_n, oe_n;

  logic        rd3;
  logic [31:0] addr3;
  logic [15:0] dq3v;
  wire  [31:0] read_data3;
  wire         ready3;
  wire  [15:0] sram_dq3;
  wire  [17:0] sram_addr3;
  wire         ub3, lb3, we3, ce3, oe3;

  always #5 clk = ~clk;

  sram_word_controller u_dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en),
    .address(address), .write_data(write_data),
    .read_data(read_data), .ready(ready),
    .SRAM_DQ(sram_dq), .SRAM_ADDR(sram_addr),
    .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n), .SRAM_WE_N(we_n),
    .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n)
  );

  sram_word_controller #(.WAIT_CYCLES(3)) u_dut3 (
    .clk(clk), .rst(rst), .wr_en(1'b0), .rd_en(rd3),
    .address(addr3), .write_data(32'h0),
    .read_data(read_data3), .ready(ready3),
    .SRAM_DQ(sram_dq3), .SRAM_ADDR(sram_addr3),
    .SRAM_UB_N(ub3), .SRAM_LB_N(lb3), .SRAM_WE_N(we3),
    .SRAM_CE_N(ce3), .SRAM_OE_N(oe3)
  );

  // Behavioural SRAM: drives reads when asked, stores while WE_N is low.
  logic [15:0] sram [0:262143];
  logic        tb_drv;
  assign sram_dq  = tb_drv ? sram[sram_addr] : 16'hzzzz;
  assign sram_dq3 = dq3v;

  always @(negedge clk) begin
    if (!we_n) sram[sram_addr] <= sram_dq;
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    bit          rd;
    logic [31:0] d;
    int          stall;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] refm[int];

  function automatic int widx(logic [31:0] a);
    logic [31:0] o;
    o = a - 32'd1024;
    return int'((o >> 2) % 32'h20000);
  endfunction

  function automatic logic [31:0] ref_rd(logic [31:0] a);
    int w;
    w = widx(a);
    return refm.exists(w) ? refm[w] : 32'h0;
  endfunction

  // Monitor: one completion per ready rise after a stall.
  int low_cnt = 0;
  always @(negedge clk) begin
    if (rst) begin
      low_cnt = 0;
      sb.delete();
    end else if (!ready) begin
      low_cnt++;
    end else if (low_cnt > 0) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("stall_len", low_cnt, e.stall);
        if (e.rd) chk("read_data", read_data, e.d);
      end
      low_cnt = 0;
    end
  end

  function automatic logic [31:0] dq_floating(logic [15:0] v);
    return ((v === 16'hzzzz) || (v === 16'h0000)) ? 32'd1 : 32'd0;
  endfunction

  // Called at posedge+1 with the DUT idle; returns at posedge+1 after DONE.
  task automatic issue(bit wr, logic [31:0] a, logic [31:0] d, bit hold);
    exp_t e;
    int k;
    wr_en      = wr;
    rd_en      = !wr;
    address    = a;
    write_data = d;
    tb_drv     = !wr;
    e.rd    = !wr;
    e.d     = ref_rd(a);
    e.stall = 5;
    sb.push_back(e);
    if (wr) refm[widx(a)] = d;
    for (k = 0; k < 40; k++) begin
      @(negedge clk);
      if (ready && k > 0) break;
    end
    chk("done_seen", (k < 40) ? 32'd1 : 32'd0, 32'd1);
    @(posedge clk);
    #1;
    if (!hold) begin
      wr_en  = 1'b0;
      rd_en  = 1'b0;
      tb_drv = 1'b0;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  logic [17:0] ea [0:5];
  logic [15:0] ed [0:5];
  logic        ew [0:5];

  initial begin
    for (int i = 0; i < 262144; i++) sram[i] = 16'h0;
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
    address = 32'h0; write_data = 32'h0; tb_drv = 1'b0;
    rd3 = 1'b0; addr3 = 32'h0; dq3v = 16'h0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_ready", ready, 1);
      chk("idle_we_n", we_n, 1);
      chk("idle_rdata", read_data, 0);
    end
    chk("idle_dq_z", dq_floating(sram_dq), 1);
    chk("const_pins", {ub_n, lb_n, ce_n, oe_n}, 0);

    // Traced write of 0xDEADBEEF at 1024.
    @(posedge clk); #1;
    begin
      exp_t e;
      e.rd = 1'b0; e.d = 32'h0; e.stall = 5;
      sb.push_back(e);
    end
    refm[widx(32'd1024)] = 32'hDEADBEEF;
    wr_en = 1'b1; address = 32'd1024; write_data = 32'hDEADBEEF;
    ea[1] = 18'd0; ea[2] = 18'd0; ea[3] = 18'd1; ea[4] = 18'd1;
    ed[1] = 16'hBEEF; ed[2] = 16'hBEEF;
    ed[3] = 16'hDEAD; ed[4] = 16'hDEAD;
    ew[0] = 1; ew[1] = 0; ew[2] = 1; ew[3] = 0; ew[4] = 1; ew[5] = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("wr_we_n_%0d", i), we_n, ew[i]);
      chk($sformatf("wr_ready_%0d", i), ready, (i == 5) ? 1 : 0);
      if (i >= 1 && i <= 4) begin
        chk($sformatf("wr_addr_%0d", i), sram_addr, ea[i]);
        chk($sformatf("wr_dq_%0d", i), sram_dq, ed[i]);
      end
    end
    @(posedge clk); #1;
    wr_en = 1'b0;
    chk("sram0", sram[0], 16'hBEEF);
    chk("sram1", sram[1], 16'hDEAD);
    issue(1'b0, 32'd1024, 32'h0, 1'b0);

    // Address map.
    issue(1'b1, 32'd1028, 32'h12345678, 1'b0);
    issue(1'b1, 32'd1032, 32'hCAFEF00D, 1'b0);
    chk("sram2", sram[2], 16'h5678);
    chk("sram3", sram[3], 16'h1234);
    chk("sram4", sram[4], 16'hF00D);
    chk("sram5", sram[5], 16'hCAFE);
    issue(1'b0, 32'd1028, 32'h0, 1'b0);
    issue(1'b0, 32'd1032, 32'h0, 1'b0);

    // Back-to-back reads with rd_en held high.
    issue(1'b0, 32'd1028, 32'h0, 1'b1);
    issue(1'b0, 32'd1032, 32'h0, 1'b1);
    issue(1'b0, 32'd1024, 32'h0, 1'b0);
    chk("rdata_hold_after_b2b", read_data, 32'hDEADBEEF);

    // Random traffic, including aliased addresses above the 17-bit word range.
    for (int n = 0; n < 60; n++) begin
      logic [31:0] a;
      a = 32'd1024 + 32'(4 * $urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) a = a + 32'h80000;
      issue($urandom_range(0, 1) == 1, a, $urandom, $urandom_range(0, 3) == 0);
    end
    wr_en = 1'b0; rd_en = 1'b0; tb_drv = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;

    // Reset during the high phase of a write.
    wr_en = 1'b1; address = 32'd1424; write_data = 32'h11112222;
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1; wr_en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", ready, 1);
    chk("rst_we_n", we_n, 1);
    chk("rst_rdata", read_data, 0);
    chk("rst_dq_z", dq_floating(sram_dq), 1);
    chk("rst_addr", sram_addr, 0);
    @(posedge clk); #1;
    issue(1'b0, 32'd1028, 32'h0, 1'b0);

    // WAIT_CYCLES=3 instance: 9-cycle stall, sample on 4th cycle of each phase.
    rd3 = 1'b1; addr3 = 32'd1044;
    for (int i = 0; i <= 9; i++) begin
      @(negedge clk);
      dq3v = (i == 4) ? 16'h1357 : (i == 8) ? 16'h2468 : 16'hBAD0;
      chk($sformatf("w3_ready_%0d", i), ready3, (i == 9) ? 1 : 0);
      chk($sformatf("w3_we_n_%0d", i), we3, 1);
      if (i >= 1 && i <= 4) chk($sformatf("w3_addr_%0d", i), sram_addr3, 18'd10);
      if (i >= 5 && i <= 8) chk($sformatf("w3_addr_%0d", i), sram_addr3, 18'd11);
    end
    chk("w3_rdata", read_data3, 32'h24681357);
    @(posedge clk); #1;
    rd3 = 1'b0;
    repeat (2) @(negedge clk);
    chk("w3_idle_ready", ready3, 1);
    chk("sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_word_controller.md
Name: sram_word_controller

Overview:
Sequences the external 16-bit SRAM on behalf of the MEM stage and presents it as a 32-bit word memory. It accepts one read or write request and splits it into two 16-bit SRAM phases, low half then high half. While the access is in flight it drives `ready` low; the MEM stage uses `~ready` as `mem_freeze` to stall IF/ID, ID/EXE, EXE/MEM and MEM/WB. It sits between the MEM stage datapath and the top-level SRAM pins.

Parameters:
WAIT_CYCLES, 1, SRAM settle cycles per 16-bit phase; phase length = WAIT_CYCLES+1 clocks; legal range 1..7.
MEM_BASE, 1024, byte address mapped to SRAM word 0.

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous active-high reset
wr_en  input  1  write request, level, held by the stalled pipeline until ready
rd_en  input  1  read request, level, held until ready
address  input  32  byte address from the ALU result
write_data  input  32  store data (val_rm)
read_data  output  32  registered load data
ready  output  1  1 = no access pending or access completing this cycle; 0 = stall
SRAM_DQ  inout  16  SRAM data bus
SRAM_ADDR  output  18  SRAM half-word address
SRAM_UB_N  output  1  constant 0
SRAM_LB_N  output  1  constant 0
SRAM_WE_N  output  1  active-low write strobe
SRAM_CE_N  output  1  constant 0
SRAM_OE_N  output  1  constant 0

Behaviour:
- Address map: word = (address - MEM_BASE) >> 2, 32-bit unsigned subtract. Low phase SRAM_ADDR = {word[16:0],1'b0}; high phase SRAM_ADDR = {word[16:0],1'b1}. Bits above word[16] are ignored, so addresses wrap silently.
- FSM states: IDLE, LO, HI, DONE. A phase counter runs 0..WAIT_CYCLES inside LO and HI.
- IDLE: if wr_en|rd_en, latch op (wr_en wins if both are set), address and write_data, then go to LO with cnt=0. Otherwise stay.
- LO/HI: cnt increments each cycle. When cnt==WAIT_CYCLES, clear cnt and advance LO->HI->DONE.
- DONE: lasts one cycle, then returns to IDLE. A request seen in the following IDLE cycle is treated as new.
- ready (combinational):
  - IDLE: ~(wr_en|rd_en)
  - LO/HI: 0
  - DONE: 1
  - Stall length is 2*(WAIT_CYCLES+1)+1 cycles including the IDLE request cycle; with the default this is ready low for 5 cycles.
- Write:
  - SRAM_DQ is driven with write_data[15:0] in LO and write_data[31:16] in HI.
  - SRAM_WE_N=0 for cycles cnt<WAIT_CYCLES of each phase and 1 on the last cycle, so address and data are stable at the WE_N rising edge.
  - SRAM_DQ is Z in all other states and for all reads.
- Read:
  - SRAM_WE_N=1 throughout.
  - On the last cycle of LO, read_data[15:0] <= SRAM_DQ; on the last cycle of HI, read_data[31:16] <= SRAM_DQ.
  - read_data is valid from DONE onward and holds until the next read overwrites it. Writes do not change read_data.
- SRAM_ADDR holds the last phase address in IDLE/DONE.
- Reset (any state, including mid-access):
  - Next edge: state=IDLE, cnt=0, read_data=0, SRAM_ADDR=0, SRAM_WE_N=1, DQ=Z.
  - A write cut off by reset may leave the SRAM partially written. This is accepted.
- Request deasserted mid-access (flush): the access still completes. Callers never do this because the pipeline is frozen.

Test Plan:
- Idle: rst then no requests for 10 cycles -> ready=1, SRAM_WE_N=1, DQ=Z, read_data=0.
- Write address=1024, data=0xDEADBEEF, default params:
  - ready low 5 cycles.
  - SRAM_ADDR=0 with DQ=0xBEEF, WE_N low 1 cycle; then SRAM_ADDR=1 with DQ=0xDEAD, WE_N low 1 cycle.
  - Then read address=1024 -> read_data=0xDEADBEEF at DONE.
- Map check: write 0x12345678 to 1028 and 0xCAFEF00D to 1032 -> SRAM[2]=0x5678, [3]=0x1234, [4]=0xF00D, [5]=0xCAFE; readbacks match.
- Back-to-back: keep rd_en=1 across two addresses in consecutive requests -> two separate 5-cycle stalls with ready=1 exactly one cycle (DONE) between them; each read_data is correct.
- Reset mid-write: assert rst in the HI phase -> next cycle IDLE, WE_N=1, DQ=Z, ready follows requests; a following read completes normally.
- WAIT_CYCLES=3: read request -> ready low 9 cycles, each SRAM_ADDR held 4 cycles, data sampled on the 4th cycle of each phase.
